// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive stage with mid-bit sampling and valid/ready byte output
module uart_receiver #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int          BAUD_DIV  = CLOCK_FREQ / BAUD_RATE;
    localparam int          HALF      = BAUD_DIV / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        rx_meta;
    logic        rx_sync;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;

    logic        baud_clr;
    logic        baud_inc;
    logic        bit_clr;
    logic        bit_inc;
    logic        shift_en;
    logic        stop_good;
    logic        stop_bad;

    // Two-flop synchronizer; idle-high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes; the sample point is the last count of each bit period
    always_comb begin
        state_next = state;
        baud_clr   = 1'b0;
        baud_inc   = 1'b0;
        bit_clr    = 1'b0;
        bit_inc    = 1'b0;
        shift_en   = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_next = START;
                    baud_clr   = 1'b1;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    if (!rx_sync) begin
                        state_next = DATA;
                        baud_clr   = 1'b1;
                        bit_clr    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_inc = 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    shift_en = 1'b1;
                    baud_clr = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end else begin
                    baud_inc = 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_clr = 1'b1;
                    if (rx_sync) begin
                        stop_good  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    baud_inc = 1'b1;
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a break is not seen as a new start bit
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Baud and bit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
        end else begin
            if (baud_clr) begin
                baud_cnt <= 16'd0;
            end else if (baud_inc) begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if (bit_clr) begin
                bit_cnt <= 3'd0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // LSB-first shift: each sample enters at bit 7 and walks down to bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 8'h00;
        end else if (shift_en) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
        end
    end

    // Byte delivery, handshake release and one-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= stop_bad;
            overrun_err <= 1'b0;
            if (stop_good && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else begin
                if (stop_good) begin
                    overrun_err <= 1'b1;
                end
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: the counterpart of the UART transmitter on the far end of the serial line. It recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from `uart_rx` by mid-bit sampling, and presents each byte on a valid/ready interface to the RX FIFO. It also flags framing errors and overrun (a byte lost because the previous byte was never accepted).

## Interface
- `CLOCK_FREQ`, default 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in baud.
- Derived: `BAUD_DIV = CLOCK_FREQ / BAUD_RATE` (integer division); `HALF = BAUD_DIV / 2`. Legal range 4 ≤ BAUD_DIV ≤ 65535.

Ports:
- `clk` in 1: clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `uart_rx` in 1: serial line, asynchronous to clk, idle high.
- `rx_data` out 8: received byte, stable while `rx_valid`=1.
- `rx_valid` out 1: byte available.
- `rx_ready` in 1: consumer accepts the byte when `rx_valid && rx_ready` at a rising edge.
- `frame_err` out 1: one-cycle pulse; stop bit sampled low.
- `overrun_err` out 1: one-cycle pulse; completed byte dropped.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun_err`=0, `busy`=0. The FSM resets to IDLE, counters reset to 0, and synchronizer flops reset to 1.
- `uart_rx` passes through a 2-flop synchronizer and produces `rx_sync`. Only `rx_sync` is used internally.
- A 16-bit `baud_cnt` and a 3-bit `bit_cnt` drive the FSM. The FSM has five states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: if `rx_sync`=0, go to START with `baud_cnt`←0.
  - START: when `baud_cnt`=HALF−1, check `rx_sync`.
    - If 0: go to DATA with `baud_cnt`←0 and `bit_cnt`←0.
    - If 1 (glitch / false start): return to IDLE, with no output activity.
    - Otherwise increment `baud_cnt`.
  - DATA: when `baud_cnt`=BAUD_DIV−1, shift `rx_sync` into the MSB of `shift_reg` (right shift, so the first bit received lands at bit 0) and set `baud_cnt`←0.
    - After the 8th sample (`bit_cnt`=7), go to STOP; otherwise increment `bit_cnt`.
  - STOP: when `baud_cnt`=BAUD_DIV−1, sample `rx_sync`.
    - If 1: deliver the byte (see below) and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for `rx_sync`=1, then go to IDLE. This prevents a held-low line (break) from being retriggered as a start bit.
- Delivery, on the stop-sample edge:
  - If `rx_valid`=0, or `rx_valid && rx_ready` in the same cycle: `rx_data`←`shift_reg` and `rx_valid`←1.
  - Otherwise: pulse `overrun_err`. `rx_data` and `rx_valid` keep the old byte; the new byte is lost.
- `rx_valid` clears on the edge where `rx_valid && rx_ready` is true and no new byte is loaded at that edge.
- `rx_ready` has no effect while `rx_valid`=0.
- Reset mid-frame aborts immediately with all outputs at their reset values. After reset, the receiver resynchronises on the next falling edge seen in IDLE.

## Timing
- Number rising edges from edge 1, the first edge at which `uart_rx` is sampled low. With that numbering:
  - `rx_sync`=0 after edge 2.
  - START is entered at edge 3.
  - DATA is entered at edge 3+HALF.
  - Data bit k is sampled at edge 3+HALF+(k+1)·BAUD_DIV, for k=0..7.
  - STOP is entered at edge 3+HALF+8·BAUD_DIV.
  - The stop sample occurs at edge 3+HALF+9·BAUD_DIV.
- `rx_valid`, `frame_err` or `overrun_err` change on the stop-sample edge itself (registered outputs).
- The FSM is back in IDLE at mid-stop-bit, so it can accept a following start bit immediately (back-to-back frames).
- `busy` rises at edge 3 and falls at the stop-sample edge, or at BREAK exit.

## Test plan
Use CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000, giving BAUD_DIV=10 and HALF=5.
- Single frame 0xA5 with good stop and `rx_ready`=1: `rx_valid` rises at edge 98, `rx_data`=0xA5, `rx_valid` clears one cycle later, and no error pulses occur.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap, with `rx_ready`=1: three bytes are delivered in order, spaced 100 cycles apart.
- False start, a 3-cycle low glitch on `uart_rx`: the FSM returns to IDLE at edge 8; `rx_valid`, `frame_err` and `busy` are low from edge 8 onward; no byte is delivered.
- Frame 0x55 with the stop bit driven 0, then the line held low for 50 cycles before going high: a single `frame_err` pulse occurs at edge 98, no `rx_valid`, `busy` stays high until the line goes high, and there is no spurious second frame.
- Two frames 0x11 then 0x22 with `rx_ready`=0: `rx_data`=0x11 and `rx_valid` stay held, and `overrun_err` pulses once at the second stop sample. Raising `rx_ready` afterwards yields 0x11 only.
- Assert `rst_n` low during data bit 4 of frame 0x81, then release and send 0x42: all outputs are 0 during reset, and exactly one byte, 0x42, is delivered.
